// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C target
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } i2c_state_e;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic [6:0] I2C_DEF_ADDR = 7'h2A;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: pin synchroniser with rise/fall detection on the last two samples
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES:0] sh;
    always_ff @(posedge clk) begin
        if (rst) sh <= '1;
        else sh <= {sh[SYNC_STAGES-1:0], d};
    end
    assign q = sh[SYNC_STAGES-1];
    assign rise = q & ~sh[SYNC_STAGES];
    assign fall = ~q & sh[SYNC_STAGES];
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a pointer-addressed register file and a local access port
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEF_ADDR,
    parameter int NUM_REGS = 16,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_W = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             loc_we,
    input  logic [PTR_W-1:0] loc_addr,
    input  logic [7:0]       loc_wdata,
    output logic [7:0]       loc_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_index,
    output logic             busy
);
    logic scl, scl_r, scl_f, sda, sda_r, sda_f;
    logic start, stop, we, oe_n, busy_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] sh, sh_n, byte_in;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [7:0] regs [NUM_REGS];
    i2c_state_e state, state_n;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .d(scl_i), .q(scl), .rise(scl_r), .fall(scl_f)
    );
    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .d(sda_i), .q(sda), .rise(sda_r), .fall(sda_f)
    );

    assign start = scl & sda_f;
    assign stop = scl & sda_r;
    assign byte_in = {sh[6:0], sda};

    // ACK states use sda_oe to tell the fall that opens the ACK slot from the one that closes it
    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        sh_n = sh;
        ptr_n = ptr;
        oe_n = sda_oe;
        we = 1'b0;
        if (start) begin
            state_n = ADDR;
            bit_cnt_n = 3'd7;
            oe_n = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n = 1'b0;
        end else if (scl_r) begin
            case (state)
                ADDR: begin
                    sh_n = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state_n = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                end
                PTR: begin
                    sh_n = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        ptr_n = byte_in[PTR_W-1:0];
                        state_n = PTR_ACK;
                    end
                end
                WDATA: begin
                    sh_n = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        we = 1'b1;
                        ptr_n = ptr + 1'b1;
                        state_n = WDATA_ACK;
                    end
                end
                RDATA_ACK: state_n = (sda == I2C_NACK) ? IGNORE : RDATA_ACK;
                default: ;
            endcase
        end else if (scl_f) begin
            case (state)
                ADDR_ACK: begin
                    bit_cnt_n = 3'd7;
                    if (!sda_oe) oe_n = ~I2C_ACK;
                    else if (sh[0]) begin
                        state_n = RDATA;
                        sh_n = regs[ptr];
                        oe_n = ~regs[ptr][7];
                    end else begin
                        state_n = PTR;
                        oe_n = 1'b0;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    bit_cnt_n = 3'd7;
                    if (!sda_oe) oe_n = ~I2C_ACK;
                    else begin
                        state_n = WDATA;
                        oe_n = 1'b0;
                    end
                end
                RDATA: begin
                    if (bit_cnt == 3'd0) begin
                        state_n = RDATA_ACK;
                        oe_n = 1'b0;
                        ptr_n = ptr + 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt - 3'd1;
                        sh_n = {sh[6:0], 1'b0};
                        oe_n = ~sh[6];
                    end
                end
                RDATA_ACK: begin
                    state_n = RDATA;
                    bit_cnt_n = 3'd7;
                    sh_n = regs[ptr];
                    oe_n = ~regs[ptr][7];
                end
                default: ;
            endcase
        end
        busy_n = (state_n == IDLE || state_n == IGNORE) ? 1'b0 : (state_n == ADDR_ACK) ? 1'b1 : busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            sh <= '0;
            ptr <= '0;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index <= '0;
        end else begin
            state <= state_n;
            bit_cnt <= bit_cnt_n;
            sh <= sh_n;
            ptr <= ptr_n;
            sda_oe <= oe_n;
            busy <= busy_n;
            wr_strobe <= we;
            if (we) wr_index <= ptr;
        end
    end

    // I2C commit is assigned last so it overrides a local write to the same index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            loc_rdata <= '0;
        end else begin
            if (loc_we) regs[loc_addr] <= loc_wdata;
            if (we) regs[ptr] <= byte_in;
            loc_rdata <= regs[loc_addr];
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: directed I2C master transactions against the register-file target
module tb_i2c_slave_regfile;
    import i2c_pkg::*;
    localparam int Q = 8;
    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, loc_we = 1'b0;
    logic [3:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic sda_line, sda_oe, wr_strobe, busy;
    logic [7:0] loc_rdata;
    logic [3:0] wr_index;
    int checks = 0, errors = 0, strobe_cnt = 0;
    logic [3:0] idx_log [16];
    logic oe_watch = 1'b0, oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            idx_log[strobe_cnt % 16] = wr_index;
            strobe_cnt++;
        end
        if (oe_watch && sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_q; scl_m = 1'b1; wait_q; sda_m = 1'b0; wait_q; scl_m = 1'b0; wait_q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_q; scl_m = 1'b1; wait_q; sda_m = 1'b1; wait_q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_q; scl_m = 1'b1; wait_q; wait_q; scl_m = 1'b0; wait_q;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic coll, input logic [3:0] caddr,
                              input logic [7:0] cdata, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q; scl_m = 1'b1;
            for (int k = 0; k < 2 * Q; k++) begin
                @(negedge clk);
                if (coll && i == 0 && k == 1) begin
                    loc_we = 1'b1; loc_addr = caddr; loc_wdata = cdata;
                end
                if (coll && i == 0 && k == 2) begin
                    loc_we = 1'b0;
                    checks++;
                    if (wr_strobe !== 1'b1) begin
                        errors++; $display("FAIL strobe_latency: got %b expected 1", wr_strobe);
                    end
                end
            end
            scl_m = 1'b0; wait_q;
        end
        sda_m = 1'b1; wait_q; scl_m = 1'b1; wait_q; ack = sda_line; wait_q; scl_m = 1'b0; wait_q;
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q; scl_m = 1'b1; wait_q; d[i] = sda_line; wait_q; scl_m = 1'b0; wait_q;
        end
        sda_m = ack_bit; wait_q; scl_m = 1'b1; wait_q; wait_q; scl_m = 1'b0; wait_q;
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk); loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a;
        repeat (2) @(negedge clk);
        d = loc_rdata;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if (wr_index !== 4'd0) begin errors++; $display("FAIL rst_wr_index: got %h expected 0", wr_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL rst_loc_rdata: got %h expected 00", loc_rdata); end
    endtask

    task automatic test_write;
        logic ack;
        logic [7:0] d;
        int s0;
        s0 = strobe_cnt;
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy); end
        write_byte(8'h03, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack: got %b expected 0", ack); end
        write_byte(8'hA5, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d0_ack: got %b expected 0", ack); end
        write_byte(8'h5A, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d1_ack: got %b expected 0", ack); end
        i2c_stop;
        repeat (4) @(negedge clk);
        checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL wr_strobes: got %0d expected 2", strobe_cnt - s0); end
        checks++; if (idx_log[s0 % 16] !== 4'd3) begin errors++; $display("FAIL wr_idx0: got %h expected 3", idx_log[s0 % 16]); end
        checks++; if (idx_log[(s0 + 1) % 16] !== 4'd4) begin errors++; $display("FAIL wr_idx1: got %h expected 4", idx_log[(s0 + 1) % 16]); end
        checks++; if (dut.ptr !== 4'd5) begin errors++; $display("FAIL wr_ptr: got %h expected 5", dut.ptr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b expected 0", busy); end
        loc_read(4'd3, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wr_reg3: got %h expected a5", d); end
        loc_read(4'd4, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wr_reg4: got %h expected 5a", d); end
    endtask

    task automatic test_read_wrap;
        logic ack;
        logic [7:0] d;
        loc_write(4'd15, 8'h11);
        loc_write(4'd0, 8'h22);
        loc_write(4'd1, 8'h33);
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h0F, 1'b0, 4'd0, 8'h00, ack);
        i2c_start;
        write_byte(8'h55, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL rd_b0: got %h expected 11", d); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL rd_b1: got %h expected 22", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL rd_b2: got %h expected 33", d); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_nack: got %b expected 0", busy); end
        i2c_stop;
        checks++; if (dut.ptr !== 4'd2) begin errors++; $display("FAIL rd_ptr: got %h expected 2", dut.ptr); end
    endtask

    task automatic test_bad_addr;
        logic ack;
        logic [7:0] d;
        int s0;
        s0 = strobe_cnt;
        oe_seen = 1'b0;
        oe_watch = 1'b1;
        i2c_start;
        write_byte(8'h56, 1'b0, 4'd0, 8'h00, ack);
        oe_watch = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bad_ack: got %b expected 1", ack); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL bad_oe: got %b expected 0", oe_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b expected 0", busy); end
        checks++; if (dut.state !== IGNORE) begin errors++; $display("FAIL bad_state: got %0d expected %0d", dut.state, IGNORE); end
        i2c_stop;
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL bad_strobe: got %0d expected %0d", strobe_cnt, s0); end
        loc_read(4'd3, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL bad_reg3: got %h expected a5", d); end
    endtask

    task automatic test_mid_stop;
        logic ack;
        logic [7:0] d;
        int s0;
        s0 = strobe_cnt;
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h08, 1'b0, 4'd0, 8'h00, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop;
        repeat (4) @(negedge clk);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL mid_strobe: got %0d expected %0d", strobe_cnt, s0); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (dut.ptr !== 4'd8) begin errors++; $display("FAIL mid_ptr: got %h expected 8", dut.ptr); end
        loc_read(4'd8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reg8: got %h expected 00", d); end
    endtask

    task automatic test_collision;
        logic ack;
        logic [7:0] d;
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h02, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'hC3, 1'b1, 4'd2, 8'hFF, ack);
        i2c_stop;
        loc_read(4'd2, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL col_same: got %h expected c3", d); end
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h02, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h96, 1'b1, 4'd6, 8'h66, ack);
        i2c_stop;
        loc_read(4'd2, d);
        checks++; if (d !== 8'h96) begin errors++; $display("FAIL col_i2c: got %h expected 96", d); end
        loc_read(4'd6, d);
        checks++; if (d !== 8'h66) begin errors++; $display("FAIL col_loc: got %h expected 66", d); end
    endtask

    task automatic test_reset_mid_read;
        logic ack;
        logic [7:0] d;
        loc_write(4'd10, 8'h00);
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h0A, 1'b0, 4'd0, 8'h00, ack);
        i2c_start;
        write_byte(8'h55, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rr_driving: got %b expected 1", sda_oe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rr_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", busy); end
        checks++; if (wr_index !== 4'd0) begin errors++; $display("FAIL rr_wr_index: got %h expected 0", wr_index); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rr_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL rr_loc_rdata: got %h expected 00", loc_rdata); end
        checks++; if (dut.ptr !== 4'd0) begin errors++; $display("FAIL rr_ptr: got %h expected 0", dut.ptr); end
        @(negedge clk);
        rst = 1'b0;
        i2c_stop;
        i2c_start;
        write_byte(8'h54, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rr_addr_ack: got %b expected 0", ack); end
        write_byte(8'h01, 1'b0, 4'd0, 8'h00, ack);
        write_byte(8'h42, 1'b0, 4'd0, 8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rr_data_ack: got %b expected 0", ack); end
        i2c_stop;
        loc_read(4'd1, d);
        checks++; if (d !== 8'h42) begin errors++; $display("FAIL rr_reg1: got %h expected 42", d); end
        loc_read(4'd15, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rr_reg15: got %h expected 00", d); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wrap;
        test_bad_addr;
        test_mid_stop;
        test_collision;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
